// File: rtl/cpu_pkg.sv
// Shared CPU types: divider op encoding, divider FSM states and the iteration count.
package cpu_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
import cpu_pkg::*;

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] out,
    output logic            busy,
    output logic            done,
    output div_state_e      dbg_state
);

    localparam int CW = $clog2(DIV_ITER);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DIV_ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic            sign1_q, sign1_d;
    logic            sign2_q, sign2_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Result for the two special operand pairs: zero divisor wins over overflow.
    function automatic logic [XLEN-1:0] forced_result(input div_op_e o,
                                                       input logic [XLEN-1:0] dividend,
                                                       input logic is_zero);
        if (is_zero) return op_is_rem(o) ? dividend : ALL_ONES;
        return op_is_rem(o) ? '0 : INT_MIN;
    endfunction

    div_op_e         in_op;
    logic            in_signed;
    logic            in_sign1;
    logic            in_sign2;
    logic            in_zero;
    logic            in_ovf;

    always_comb begin
        in_op     = div_op_e'(op);
        in_signed = op_is_signed(in_op);
        in_sign1  = in_signed & in1[XLEN-1];
        in_sign2  = in_signed & in2[XLEN-1];
        in_zero   = (in2 == '0);
        in_ovf    = in_signed && (in1 == INT_MIN) && (in2 == ALL_ONES);
    end

    // One restoring step: shift {rem,quo} left, trial-subtract, keep if non-negative.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        q_bit    = ~diff[XLEN];
        step_rem = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], q_bit};
    end

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        q_fix = (sign1_q ^ sign2_q) ? (~quo_q + 1'b1) : quo_q;
        r_fix = sign1_q ? (~rem_q + 1'b1) : rem_q;
        if (zero_q || ovf_q) begin
            fix_result = forced_result(op_q, dvd_q, zero_q);
        end else begin
            fix_result = op_is_rem(op_q) ? r_fix : q_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = in_op;
                    sign1_d = in_sign1;
                    sign2_d = in_sign2;
                    zero_d  = in_zero;
                    ovf_d   = in_ovf;
                    dvd_d   = in1;
                    quo_d   = in_sign1 ? (~in1 + 1'b1) : in1;
                    dvs_d   = in_sign2 ? (~in2 + 1'b1) : in2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_zero || in_ovf) begin
                        out_d   = forced_result(in_op, in1, in_zero);
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
                out_d   = fix_result;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_DIV;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 SHALL have port in1  input  XLEN  dividend.
REQ-007 SHALL have port in2  input  XLEN  divisor.
REQ-008 SHALL have port out  output  XLEN  result, registered and held until the next completion.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the cycle in which out is valid.

Function
REQ-011 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-012 SHALL, in IDLE with start=1, latch op, the sign flags, |in1| and |in2| (absolute value only for DIV/REM), clear the remainder and iteration counter, and go to CALC.
REQ-013 SHALL, in CALC, perform one radix-2 restoring step per cycle: shift {rem,quo} left 1, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
REQ-014 SHALL run exactly 32 CALC cycles, counter 0..31, and go to FIX on the edge where the counter is 31.
REQ-015 SHALL, in FIX, apply the sign correction (quotient negated if sign1^sign2; remainder takes the sign of the dividend), register out, and go to DONE.
REQ-016 SHALL hold done=1 for exactly the DONE cycle and return to IDLE on the next edge.
REQ-017 SHALL have a latency from the start-sampling edge to the done cycle of 34 cycles.
REQ-018 SHALL, for a zero divisor, force DIV/DIVU to all-ones and REM/REMU to in1, overriding the sign correction.
REQ-019 SHALL, for DIV/REM with in1=0x80000000 and in2=0xFFFFFFFF, force DIV to 0x80000000 and REM to 0.
REQ-020 SHALL ignore start while busy=1; the latched operands SHALL be unaffected.
REQ-021 SHALL not alter out except in FIX (or in the early-out path); out holds between operations.
REQ-022 SHALL accept a start in the cycle after DONE (the IDLE cycle); back-to-back issue SHALL cost 35 cycles per operation.

Reset
REQ-023 SHALL, when rst=1, on the next edge force state=IDLE, out=0, done=0, busy=0, counter=0 and remainder=0, with rst taking priority over start.
REQ-024 SHALL, on a reset mid-operation (CALC or FIX), abandon the operation, produce no done pulse, and leave out=0.

Configuration
REQ-025 SHALL support the macro DIV_EARLY_OUT_EN; when it is defined, a divide-by-zero or overflow operand pair seen in IDLE with start=1 SHALL go directly to DONE with the forced result registered, giving done 1 cycle after start.
REQ-026 SHALL, when DIV_EARLY_OUT_EN is undefined, send every operation through CALC/FIX with the 34-cycle latency, with the REQ-018/019 results applied in FIX.

Structure
REQ-027 SHALL take the op encoding typedef (div_op_e) and the state typedef (div_state_e) from the shared package cpu_pkg, together with the constant DIV_ITER=32.
REQ-028 SHALL be a single module; the iteration step SHALL be inline logic with no sub-module.

Verification
REQ-029 SHALL verify: DIVU in1=100, in2=7 -> out=14 with done exactly 34 cycles after start; then REMU with the same operands -> out=2.
REQ-030 SHALL verify: DIV in1=0xFFFFFFF9 (-7), in2=2 -> out=0xFFFFFFFD (-3); REM with the same operands -> out=0xFFFFFFFF (-1).
REQ-031 SHALL verify: DIV in1=0x80000000, in2=0xFFFFFFFF -> out=0x80000000; REM -> out=0; done at 34 cycles without the macro and at 1 cycle with it.
REQ-032 SHALL verify: DIVU 5/0 -> out=0xFFFFFFFF; REMU 5/0 -> out=5; DIV -5/0 -> out=0xFFFFFFFF; REM -5/0 -> out=0xFFFFFFFB.
REQ-033 SHALL verify: a start pulse with different operands at CALC cycle 5 is ignored, and the original result completes unchanged.
REQ-034 SHALL verify: rst asserted at CALC cycle 10 gives busy=0 and out=0 on the next cycle with no done pulse, and a following DIVU 9/3 -> out=3.
